// File: rtl/vga_sync_last_2.sv
// Free-running VGA timing generator, SVGA 800x600@60 from a 40 MHz pixel clock; outputs registered from next counter value.
// Define VGA_SYNC_POSITIVE_POLARITY_EN for active-high hsync/vsync (default build is active-low).
module vga_sync_last_2 #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync_sig,
  output logic        vsnyc_sig,
  output logic        ready,
  output logic [10:0] column_addr_sig,
  output logic [10:0] row_addr_sig
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] H_VIS_LO   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_VIS_HI   = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [10:0] V_VIS_LO   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_VIS_HI   = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);

`ifdef VGA_SYNC_POSITIVE_POLARITY_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_wrap;
  logic        h_vis;
  logic        v_vis;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        rdy_nxt;
  logic [10:0] col_nxt;
  logic [10:0] row_nxt;

  // Line counter wraps every H_TOTAL clocks; frame counter steps on that same wrap.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end
  end

  // Decode from the next counter value so the registered outputs line up with the counters.
  always_comb begin
    h_vis   = (h_nxt >= H_VIS_LO) && (h_nxt <= H_VIS_HI);
    v_vis   = (v_nxt >= V_VIS_LO) && (v_nxt <= V_VIS_HI);
    rdy_nxt = h_vis && v_vis;
    hs_nxt  = (h_nxt < H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
    vs_nxt  = (v_nxt < V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
    col_nxt = 11'd0;
    row_nxt = 11'd0;
    if (rdy_nxt) begin
      col_nxt = h_nxt - H_VIS_LO;
      row_nxt = v_nxt - V_VIS_LO;
    end
  end

  // Reset parks the counters on the last position so release starts at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt           <= H_LAST;
      v_cnt           <= V_LAST;
      hsync_sig       <= ~SYNC_ON;
      vsnyc_sig       <= ~SYNC_ON;
      ready           <= 1'b0;
      column_addr_sig <= 11'd0;
      row_addr_sig    <= 11'd0;
    end else begin
      h_cnt           <= h_nxt;
      v_cnt           <= v_nxt;
      hsync_sig       <= hs_nxt;
      vsnyc_sig       <= vs_nxt;
      ready           <= rdy_nxt;
      column_addr_sig <= col_nxt;
      row_addr_sig    <= row_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_last_2.sv
// Bench: full-size instance (line timing, first pixel, mid-frame reset) plus a shrunken instance for whole-frame checks.
module tb_vga_sync_last_2;

`ifdef VGA_SYNC_POSITIVE_POLARITY_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        hsync_a, vsync_a, ready_a;
  logic [10:0] col_a, row_a;
  logic        hsync_b, vsync_b, ready_b;
  logic [10:0] col_b, row_b;

  always #5 clk = ~clk;

  vga_sync_last_2 dut_a (
    .clk(clk), .rst(rst_a), .hsync_sig(hsync_a), .vsnyc_sig(vsync_a), .ready(ready_a),
    .column_addr_sig(col_a), .row_addr_sig(row_a)
  );

  // Small frame: line 4+3+10+2 = 19 clocks, frame 2+3+5+1 = 11 lines = 209 clocks.
  vga_sync_last_2 #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .hsync_sig(hsync_b), .vsnyc_sig(vsync_b), .ready(ready_b),
    .column_addr_sig(col_b), .row_addr_sig(row_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: position derived from clocks elapsed since the first (0,0) clock.
  function automatic logic [24:0] model(input int t, input int hs, input int hb, input int ha,
                                        input int hf, input int vs, input int vb, input int va,
                                        input int vf);
    int h, v, ht, vt;
    logic hsy, vsy, rd;
    logic [10:0] c, r;
    if (t < 0) return {~SYNC_ON, ~SYNC_ON, 1'b0, 22'd0};
    ht  = hs + hb + ha + hf;
    vt  = vs + vb + va + vf;
    h   = t % ht;
    v   = (t / ht) % vt;
    hsy = (h < hs) ? SYNC_ON : ~SYNC_ON;
    vsy = (v < vs) ? SYNC_ON : ~SYNC_ON;
    rd  = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
    c   = rd ? 11'(h - hs - hb) : 11'd0;
    r   = rd ? 11'(v - vs - vb) : 11'd0;
    return {hsy, vsy, rd, c, r};
  endfunction

  logic [24:0] q_a[$];
  logic [24:0] q_b[$];
  int ta = -1, tb = -1, cyc = 0;

  // Line-level tracking, full-size instance
  logic prev_hs_a = 1'b0, prev_rdy_a = 1'b0, arm_a = 1'b0;
  int   last_on_a = -1, rise_a = -1, rel_a = -1;
  // Frame-level tracking, small instance
  logic prev_vs_b = 1'b0, prev_rdy_b = 1'b0, arm_b = 1'b0;
  int   last_vs_b = -1, rel_b = -1, cnt_b = 0;
  logic [10:0] lcol_b = '0, lrow_b = '0;

  task automatic step(input logic ra, input logic rb);
    logic act;
    @(negedge clk);
    rst_a = ra;
    rst_b = rb;
    ta = ra ? -1 : ta + 1;
    tb = rb ? -1 : tb + 1;
    q_a.push_back(model(ta, 128, 88, 800, 40, 4, 23, 600, 1));
    q_b.push_back(model(tb, 4, 3, 10, 2, 2, 3, 5, 1));
    @(posedge clk);
    #1;
    cyc++;
    check("a_outputs", 32'({hsync_a, vsync_a, ready_a, col_a, row_a}), 32'(q_a.pop_front()));
    check("b_outputs", 32'({hsync_b, vsync_b, ready_b, col_b, row_b}), 32'(q_b.pop_front()));

    act = (hsync_a == SYNC_ON);
    if (ra) begin
      last_on_a = -1;
      rise_a    = -1;
      arm_a     = 1'b1;
      rel_a     = cyc + 1;
    end else begin
      if (act && !prev_hs_a) begin
        if (last_on_a >= 0) check("hs_period", 32'(cyc - last_on_a), 32'd1056);
        last_on_a = cyc;
      end
      if (!act && prev_hs_a && last_on_a >= 0) check("hs_width", 32'(cyc - last_on_a), 32'd128);
      if (ready_a && !prev_rdy_a) begin
        check("rdy_rise_col", 32'(col_a), 32'd0);
        if (last_on_a >= 0) check("rdy_after_hs", 32'(cyc - last_on_a), 32'd216);
        if (arm_a) begin
          check("first_pix_dly", 32'(cyc - rel_a), 32'd28728);
          check("first_pix_row", 32'(row_a), 32'd0);
          arm_a = 1'b0;
        end
        rise_a = cyc;
      end
      if (!ready_a && prev_rdy_a && rise_a >= 0) begin
        check("rdy_len", 32'(cyc - rise_a), 32'd800);
        check("rdy_fall_col", 32'(col_a), 32'd0);
      end
    end
    prev_hs_a  = act;
    prev_rdy_a = ready_a;

    act = (vsync_b == SYNC_ON);
    if (rb) begin
      last_vs_b = -1;
      cnt_b     = 0;
      arm_b     = 1'b1;
      rel_b     = cyc + 1;
    end else begin
      if (act && !prev_vs_b) begin
        if (last_vs_b >= 0) begin
          check("vs_period", 32'(cyc - last_vs_b), 32'd209);
          check("frame_pix", 32'(cnt_b), 32'd50);
          check("last_col", 32'(lcol_b), 32'd9);
          check("last_row", 32'(lrow_b), 32'd4);
        end
        last_vs_b = cyc;
        cnt_b     = 0;
      end
      if (!act && prev_vs_b && last_vs_b >= 0) check("vs_width", 32'(cyc - last_vs_b), 32'd38);
      if (ready_b) begin
        if (!prev_rdy_b && arm_b) begin
          check("b_first_pix_dly", 32'(cyc - rel_b), 32'd102);
          arm_b = 1'b0;
        end
        cnt_b++;
        lcol_b = col_b;
        lrow_b = row_b;
      end
    end
    prev_vs_b  = act;
    prev_rdy_b = ready_b;
  endtask

  initial begin
    logic b_done;
    b_done = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    // Run the big instance into line 29; reset the small one once mid-frame at v=6, h=8.
    while (ta < 29 * 1056 + 500) begin
      if (!b_done && tb == 3 * 209 + 6 * 19 + 8) begin
        b_done = 1'b1;
        step(1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b0);
      end
    end
    // One-clock reset of the big instance at v=29, h=500, then run past its next first pixel.
    step(1'b1, 1'b0);
    for (int i = 0; i < 29900; i++) step(1'b0, 1'b0);
    check("first_pix_seen", 32'(arm_a), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
